// File: rtl/opcodes.sv
// Shared RISC-V opcode and field constants plus the R-type request record and encoder.
package opcodes;

  localparam logic [6:0] TYPE_R      = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
  } rtype_req_t;

  function automatic logic [31:0] encode_r(rtype_req_t r);
    return {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, TYPE_R};
  endfunction

endpackage

// File: rtl/rtype_req_fifo.sv
// Request queue for rtype_issuer: DEPTH entries of one R-type field record each.
module rtype_req_fifo
  import opcodes::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  rtype_req_t wdata,
  output logic       full,
  output logic       empty,
  output rtype_req_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rtype_req_t  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rtype_issuer.sv
// Queues R-type field requests, strobes each encoded word into the core IR and awaits writeback.
// Define RTYPE_ISSUER_FUNCT7_CHECK_EN to reject entries whose funct7 is not base/alt.
module rtype_issuer
  import opcodes::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_funct7,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  output logic        write_ir,
  output logic [31:0] instruction,
  input  logic        reg_write,
  input  logic [4:0]  w_reg,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        illegal_err,
  output logic [15:0] retired_count
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  rd_q, rd_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [15:0] count_q, count_d;
  logic        fifo_full, fifo_empty, fifo_pop;
  rtype_req_t  fifo_head, req;
  logic        match;

  assign req = '{funct7: req_funct7, rs2: req_rs2, rs1: req_rs1, funct3: req_funct3, rd: req_rd};

  rtype_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (req_valid),
    .pop  (fifo_pop),
    .wdata(req),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

  // rd == x0 has no visible writeback target, so any write retires it.
  assign match = reg_write && ((w_reg == rd_q) || (rd_q == 5'd0));

`ifdef RTYPE_ISSUER_FUNCT7_CHECK_EN
  logic illegal_q, illegal_d;
  logic head_legal;
  assign head_legal  = (fifo_head.funct7 == FUNCT7_BASE) || (fifo_head.funct7 == FUNCT7_ALT);
  assign illegal_err = illegal_q;
`else
  assign illegal_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    instr_d   = instr_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    count_d   = count_q;
    fifo_pop  = 1'b0;
`ifdef RTYPE_ISSUER_FUNCT7_CHECK_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
`ifdef RTYPE_ISSUER_FUNCT7_CHECK_EN
          if (!head_legal) begin
            illegal_d = 1'b1;
          end else begin
            instr_d = encode_r(fifo_head);
            rd_d    = fifo_head.rd;
            state_d = StIssue;
          end
`else
          instr_d = encode_r(fifo_head);
          rd_d    = fifo_head.rd;
          state_d = StIssue;
`endif
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (match) begin
          done_d  = 1'b1;
          count_d = count_q + 16'd1;
          state_d = StIdle;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      instr_q   <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
`ifdef RTYPE_ISSUER_FUNCT7_CHECK_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      instr_q   <= instr_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
`ifdef RTYPE_ISSUER_FUNCT7_CHECK_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign req_ready     = !fifo_full;
  assign write_ir      = (state_q == StIssue);
  assign instruction   = instr_q;
  assign busy          = (state_q != StIdle) || !fifo_empty;
  assign done          = done_q;
  assign timeout_err   = timeout_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_rtype_issuer.sv
// Scoreboard bench for rtype_issuer: pushes expected words on request, monitor checks each write_ir.
module tb_rtype_issuer;
  import opcodes::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_funct7;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic        write_ir;
  logic [31:0] instruction;
  logic        reg_write;
  logic [4:0]  w_reg;
  logic        busy, done, timeout_err, illegal_err;
  logic [15:0] retired_count;

  int n_checks = 0;
  int n_pass = 0;
  int issue_cnt = 0;
  int done_cnt = 0;
  int n_expected = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rtype_issuer #(
    .DEPTH  (4),
    .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct7   (req_funct7),
    .req_funct3   (req_funct3),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_rd       (req_rd),
    .write_ir     (write_ir),
    .instruction  (instruction),
    .reg_write    (reg_write),
    .w_reg        (w_reg),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .illegal_err  (illegal_err),
    .retired_count(retired_count)
  );

  task automatic record(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    record(act === exp, name, act, exp);
  endtask

  // Monitor: every IR strobe must match the oldest expected word.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (write_ir === 1'b1) begin
      issue_cnt++;
      if (exp_q.size() == 0) begin
        record(1'b0, "sb_unexpected_issue", instruction, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", instruction, e);
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                      input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] word,
                      input bit issues);
    int n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (!req_ready) record(1'b0, "push_ready_wait", 32'(req_ready), 32'h1);
    req_valid  = 1'b1;
    req_funct7 = f7;
    req_rs2    = r2;
    req_rs1    = r1;
    req_funct3 = f3;
    req_rd     = rd;
    step();
    req_valid = 1'b0;
    if (issues) begin
      exp_q.push_back(word);
      n_expected++;
    end
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    while (write_ir !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (write_ir !== 1'b1) record(1'b0, name, 32'(write_ir), 32'h1);
  endtask

  task automatic ack(input logic [4:0] w);
    reg_write = 1'b1;
    w_reg     = w;
    step();
    reg_write = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, instruction, 32'h0);
    check({tag, "_write_ir"}, 32'(write_ir), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    check({tag, "_illegal_err"}, 32'(illegal_err), 32'h0);
    check({tag, "_retired"}, 32'(retired_count), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, wanted finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int base_issue;
    int base_done;
    reset = 1'b1;
    req_valid = 1'b0;
    req_funct7 = '0;
    req_funct3 = '0;
    req_rs1 = '0;
    req_rs2 = '0;
    req_rd = '0;
    reg_write = 1'b0;
    w_reg = '0;
    #2 reset = 1'b0;
    step();
    step();
    check_reset_outputs("init");
    reset = 1'b1;
    step();

    // Single add x3,x1,x2: strobe two cycles after the push edge, then retire.
    push(FUNCT7_BASE, 5'd2, 5'd1, F3_ADD_SUB, 5'd3, 32'h002081B3, 1'b1);
    check("t1_no_ir_yet", 32'(write_ir), 32'h0);
    step();
    check("t1_ir_strobe", 32'(write_ir), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    step();
    check("t1_ir_one_cycle", 32'(write_ir), 32'h0);
    ack(5'd3);
    check("t1_done", 32'(done), 32'h1);
    check("t1_retired", 32'(retired_count), 32'd1);
    step();
    check("t1_done_pulse", 32'(done), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);

    // Back-to-back sub then add; the second waits for the first to retire.
    push(FUNCT7_ALT, 5'd7, 5'd6, F3_ADD_SUB, 5'd5, 32'h407302B3, 1'b1);
    push(FUNCT7_BASE, 5'd2, 5'd1, F3_ADD_SUB, 5'd3, 32'h002081B3, 1'b1);
    base_issue = issue_cnt;
    wait_issue("t2_issue1");
    step();
    step();
    step();
    step();
    check("t2_hold_second", 32'(issue_cnt), 32'(base_issue + 1));
    ack(5'd5);
    wait_issue("t2_issue2");
    step();
    ack(5'd3);
    check("t2_retired", 32'(retired_count), 32'd3);

    // Queue full: one in flight plus four queued.
    push(FUNCT7_BASE, 5'd0, 5'd0, F3_SLL, 5'd1, 32'h000010B3, 1'b1);
    push(FUNCT7_BASE, 5'd0, 5'd0, F3_SLT, 5'd2, 32'h00002133, 1'b1);
    push(FUNCT7_BASE, 5'd0, 5'd0, F3_SLTU, 5'd3, 32'h000031B3, 1'b1);
    push(FUNCT7_BASE, 5'd0, 5'd0, F3_XOR, 5'd4, 32'h00004233, 1'b1);
    push(FUNCT7_BASE, 5'd0, 5'd0, F3_OR, 5'd5, 32'h000062B3, 1'b1);
    check("t3_full", 32'(req_ready), 32'h0);
    req_valid  = 1'b1;
    req_funct3 = F3_AND;
    req_rd     = 5'd9;
    step();
    req_valid = 1'b0;
    check("t3_still_full", 32'(req_ready), 32'h0);
    ack(5'd1);
    k = 0;
    while (!req_ready && k < 4) begin
      step();
      k++;
    end
    check("t3_ready_back", 32'(req_ready), 32'h1);
    for (int i = 2; i <= 5; i++) begin
      wait_issue("t3_drain_issue");
      step();
      ack(5'(i));
    end
    check("t3_retired", 32'(retired_count), 32'd8);

    // Timeout: rd=3 only sees writes to x4; next entry still issues.
    push(FUNCT7_BASE, 5'd2, 5'd1, F3_AND, 5'd3, 32'h0020F1B3, 1'b1);
    push(FUNCT7_BASE, 5'd6, 5'd5, F3_OR, 5'd4, 32'h0062E233, 1'b1);
    wait_issue("t4_issue");
    step();
    base_done = done_cnt;
    reg_write = 1'b1;
    w_reg = 5'd4;
    k = 0;
    while (!timeout_err && k < 40) begin
      step();
      k++;
    end
    reg_write = 1'b0;
    check("t4_timeout_cycles", 32'(k), 32'd16);
    check("t4_timeout_err", 32'(timeout_err), 32'h1);
    check("t4_no_done", 32'(done_cnt), 32'(base_done));
    wait_issue("t4_next_issue");
    step();
    ack(5'd4);
    check("t4_sticky", 32'(timeout_err), 32'h1);
    check("t4_retired", 32'(retired_count), 32'd9);

    // Reset mid-WAIT with another entry queued behind.
    push(FUNCT7_ALT, 5'd11, 5'd10, F3_ADD_SUB, 5'd7, 32'h40B503B3, 1'b1);
    push(FUNCT7_BASE, 5'd1, 5'd1, F3_XOR, 5'd8, 32'h0, 1'b0);
    wait_issue("t5_issue");
    step();
    #2 reset = 1'b0;
    #1 check_reset_outputs("t5_rst");
    step();
    reset = 1'b1;
    base_issue = issue_cnt;
    repeat (5) step();
    check("t5_queue_flushed", 32'(issue_cnt), 32'(base_issue));
    check("t5_idle", 32'(busy), 32'h0);

    // rd=x0 retires on a write to any register.
    push(FUNCT7_BASE, 5'd9, 5'd8, F3_XOR, 5'd0, 32'h00944033, 1'b1);
    wait_issue("t6_issue");
    step();
    ack(5'd17);
    check("t6_done", 32'(done), 32'h1);
    check("t6_retired", 32'(retired_count), 32'd1);

    // Match on the last timer cycle beats timeout.
    push(FUNCT7_ALT, 5'd3, 5'd2, F3_SRL_SRA, 5'd6, 32'h40315333, 1'b1);
    wait_issue("t7_issue");
    step();
    repeat (15) step();
    check("t7_pre_timeout", 32'(timeout_err), 32'h0);
    check("t7_pre_done", 32'(done), 32'h0);
    ack(5'd6);
    check("t7_done", 32'(done), 32'h1);
    check("t7_no_timeout", 32'(timeout_err), 32'h0);
    check("t7_retired", 32'(retired_count), 32'd2);

    // Non-standard funct7.
`ifdef RTYPE_ISSUER_FUNCT7_CHECK_EN
    base_issue = issue_cnt;
    push(7'h01, 5'd2, 5'd1, F3_ADD_SUB, 5'd3, 32'h0, 1'b0);
    repeat (6) step();
    check("t8_illegal", 32'(illegal_err), 32'h1);
    check("t8_not_issued", 32'(issue_cnt), 32'(base_issue));
    check("t8_idle", 32'(busy), 32'h0);
`else
    push(7'h01, 5'd2, 5'd1, F3_ADD_SUB, 5'd3, 32'h022081B3, 1'b1);
    wait_issue("t8_issue");
    step();
    ack(5'd3);
    check("t8_illegal_tied", 32'(illegal_err), 32'h0);
    check("t8_retired", 32'(retired_count), 32'd3);
`endif

    step();
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    check("sb_issue_count", 32'(issue_cnt), 32'(n_expected));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
